// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the memory / write-back stage.
//   mem_state_t : memory-access FSM states (IDLE, WAIT)
//   XZR         : register index of the zero register; writes to it are dropped
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/mem_wb_staged_if.sv
// Data-memory request/response bus between the MEM stage and data memory.
//   master : MEM stage (drives req/addr/wdata/we, receives ack/rdata)
//   slave  : data memory
interface mem_wb_staged_if #(
  parameter int DATA_W = 64
);

  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_addr, dmem_wdata, dmem_req, dmem_we,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_addr, dmem_wdata, dmem_req, dmem_we,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_wb_staged_reg.sv
// Width-parameterised pipeline register with load enable and asynchronous
// active-low clear.
//   clk, reset_n : clock, async active-low clear
//   en           : load d into q on the rising edge
//   d / q        : data in / registered data out
module mem_wb_staged_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_staged.sv
// MEM/WB stage with a variable-latency data-memory handshake.
//   clk, reset_n         : clock, asynchronous active-low reset
//   *_in                 : operation arriving from EX
//   dmem                 : data-memory bus (master side)
//   *_WB, MemStage_out   : write-back registers feeding register fetch
//   Mem_out/Mem_fwd_valid: forwarding value and its qualifier
//   stall / stall_cnt    : pipeline stall request and saturating stall counter
module mem_wb_staged
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ALU_in,
  input  logic [DATA_W-1:0] StoreData_in,
  input  logic [DATA_W-1:0] PCPlusFour_in,
  input  logic [4:0]        Aw_in,
  input  logic              valid_in,
  input  logic              MemToReg_in,
  input  logic              MemWrite_in,
  input  logic              RegWrite_in,
  input  logic              Rd_X30_in,
  mem_wb_staged_if.master   dmem,
  output logic [DATA_W-1:0] PCPlusFour_WB,
  output logic [DATA_W-1:0] MemStage_out,
  output logic [4:0]        Aw_WB,
  output logic              Rd_X30_WB,
  output logic              RegWrite_WB,
  output logic [DATA_W-1:0] Mem_out,
  output logic              Mem_fwd_valid,
  output logic              stall,
  output logic [15:0]       stall_cnt
);

  localparam int WB_W = 2 * DATA_W + 5 + 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  mem_state_t        state;
  logic [DATA_W-1:0] req_addr, req_wdata, req_pc4;
  logic [4:0]        req_aw;
  logic              req_we, req_load, req_rw, req_x30;

  logic              in_wait, mem_op, access, done;
  logic [DATA_W-1:0] op_addr, op_wdata, op_pc4, wb_data;
  logic [4:0]        op_aw;
  logic              op_we, op_load, op_rw, op_x30, wb_rw;
  logic [WB_W-1:0]   wb_bus_p0;

  assign in_wait = (state == WAIT);
  assign mem_op  = valid_in & (MemToReg_in | MemWrite_in);

  // While waiting, the latched request is the op in flight; EX inputs are ignored.
  assign op_addr  = in_wait ? req_addr  : ALU_in;
  assign op_wdata = in_wait ? req_wdata : StoreData_in;
  assign op_pc4   = in_wait ? req_pc4   : PCPlusFour_in;
  assign op_aw    = in_wait ? req_aw    : Aw_in;
  assign op_we    = in_wait ? req_we    : MemWrite_in;
  assign op_load  = in_wait ? req_load  : MemToReg_in;
  assign op_rw    = in_wait ? req_rw    : RegWrite_in;
  assign op_x30   = in_wait ? req_x30   : Rd_X30_in;

  // Gating with reset_n keeps the bus quiet during reset even if EX shows a mem op.
  assign access = reset_n & (in_wait | mem_op);
  assign done   = reset_n & (in_wait ? dmem.dmem_ack : (valid_in & (~mem_op | dmem.dmem_ack)));
  assign stall  = access & ~dmem.dmem_ack;

  assign dmem.dmem_req   = access;
  assign dmem.dmem_addr  = op_addr;
  assign dmem.dmem_wdata = op_wdata;
  assign dmem.dmem_we    = access & op_we;

  assign wb_data = op_load ? dmem.dmem_rdata : op_addr;
  assign wb_rw   = op_rw & ~op_we & (op_aw != XZR);

  assign Mem_out       = reset_n ? op_addr : '0;
  assign Mem_fwd_valid = reset_n & ~in_wait & valid_in & ~MemToReg_in & RegWrite_in
                         & (Aw_in != XZR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_pc4   <= '0;
      req_aw    <= '0;
      req_we    <= 1'b0;
      req_load  <= 1'b0;
      req_rw    <= 1'b0;
      req_x30   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !dmem.dmem_ack) begin
            state     <= WAIT;
            req_addr  <= ALU_in;
            req_wdata <= StoreData_in;
            req_pc4   <= PCPlusFour_in;
            req_aw    <= Aw_in;
            req_we    <= MemWrite_in;
            req_load  <= MemToReg_in;
            req_rw    <= RegWrite_in;
            req_x30   <= Rd_X30_in;
          end
        end
        WAIT: begin
          if (dmem.dmem_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end

  // ---- WB stage boundary: payload holds on bubbles, RegWrite loads every edge ----
  mem_wb_staged_reg #(.WIDTH(WB_W)) u_wb_data_p0 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (done),
    .d       ({op_pc4, wb_data, op_aw, op_x30}),
    .q       (wb_bus_p0)
  );

  mem_wb_staged_reg #(.WIDTH(1)) u_wb_rw_p0 (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .d       (done & wb_rw),
    .q       (RegWrite_WB)
  );

  assign {PCPlusFour_WB, MemStage_out, Aw_WB, Rd_X30_WB} = wb_bus_p0;

endmodule
